truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential, parametrised successor to the fixed 3-input combinational function blocks in our lab sets. It holds an N-input Boolean function as a loadable truth-table register and, on `start`, walks every minterm 0..2^N-1 in order. For each minterm it emits the variable vector, the minterm index and the function output. It also accumulates a count of true minterms and a minterm mask, so that the canonical sum-of-products can be read back when the sweep finishes. It feeds the lab display/monitor logic and replaces hand-written `#1` minterm sweeps in benches.

## Interface
- `N`, 3: number of function inputs; 1 ≤ N ≤ 6.
- `TT_INIT`, 8'hF4 (sized 2^N): reset value of the truth table; bit m is the output for minterm m.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tt_load`  in  1: load `tt_in` into the truth-table register.
- `tt_in`  in  2^N: new truth table, bit m is the output for minterm m.
- `start`  in  1: begin a sweep; single-cycle pulse or level.
- `ready`  in  1: consumer accepts the current step. Present only with `TT_SWEEP_STALL_EN`.
- `valid`  out  1: `minterm`/`vars`/`f_out` hold a valid step.
- `minterm`  out  N: current minterm index.
- `vars`  out  N: variable values; MSB is the first variable (a), so `vars` == `minterm`.
- `f_out`  out  1: truth-table bit for the current minterm.
- `busy`  out  1: high while in SWEEP.
- `done`  out  1: one-cycle pulse after the last step is accepted.
- `ones_count`  out  N+1: number of accepted steps with `f_out`=1.
- `sop_mask`  out  2^N: bit m set when minterm m was accepted with `f_out`=1.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - `start` → SWEEP. On that edge `minterm`←0, `ones_count`←0, `sop_mask`←0.
  - `tt_load` writes the truth-table register.
  - If `start` and `tt_load` are asserted together, the load takes effect first; the sweep uses the new table.
- SWEEP:
  - `valid`=1 and `f_out`=tt[minterm].
  - A step is accepted when `valid`=1, qualified by `ready` if stall is enabled.
  - On acceptance: `ones_count`+=`f_out`, `sop_mask[minterm]`|=`f_out`, and `minterm`+1.
  - At `minterm`=2^N-1, acceptance moves to DONE. `minterm` holds its value; it does not wrap to 0.
- DONE:
  - `done`=1 and `valid`=0 for exactly one cycle, then IDLE.
  - `start` in DONE goes directly to SWEEP with counters cleared.
- Ignored inputs:
  - `start` is ignored in SWEEP.
  - `tt_load` is ignored in SWEEP, so the table is stable for the whole sweep; it is honoured in IDLE and DONE.
- Results hold: `ones_count` and `sop_mask` keep their values after DONE until the next start or reset.
- Width: `ones_count` reaches 2^N without overflow, hence N+1 bits.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `valid`, `busy`, `done` = 0.
  - `minterm`, `vars`, `f_out` = 0.
  - `ones_count`, `sop_mask` = 0.
  - Truth table = `TT_INIT`.
- `start` sampled at edge k → `valid`/`busy` high after edge k, with `minterm`=0.
- Without stall, the last step is visible in cycle k+2^N-1, `done` is high in cycle k+2^N, and `busy` falls at the same edge `done` rises.
- Minimum repeat interval is 2^N+1 cycles.
- `rst` mid-sweep clears everything immediately (asynchronous). No `done` pulse is produced and no partial results are retained.

## Configuration
- `TT_SWEEP_STALL_EN` defined:
  - `ready` port exists.
  - With `ready`=0, `minterm`, `f_out` and `valid` hold and the accumulators are unchanged.
  - `done` follows the acceptance of the last minterm by one cycle.
- Undefined:
  - No `ready` port; every valid cycle is accepted.
  - Sweep length is fixed at 2^N cycles.

## Test plan
- Default table (N=3): `start` pulse → `f_out` sequence 0,0,1,0,1,1,1,1 for minterms 0..7, then `done` one cycle later; `ones_count`=5, `sop_mask`=8'hF4.
- `tt_load` `tt_in`=8'h96 in IDLE, then `start` → `ones_count`=4, `sop_mask`=8'h96. A second `tt_load` of 8'hFF during SWEEP has no effect on this sweep.
- `start` re-pulsed at minterm 3 in SWEEP → ignored; sweep still ends at minterm 7 with one `done` pulse.
- `rst` asserted while `minterm`=4 → `valid`, `busy` and counters read 0 before the next edge; the truth table returns to 8'hF4.
- With `TT_SWEEP_STALL_EN`: `ready`=0 for 3 cycles at minterm 2 → `minterm`=2 and `f_out`=1 hold; `ones_count` increments once; `done` occurs 3 cycles later than the no-stall case.
- With N=4 and `TT_INIT`=16'h8001, `start` → `ones_count`=2, `sop_mask`=16'h8001; `done` at cycle k+16.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: holds an N-input Boolean function as a loadable truth
// table and, on start, walks minterms 0..2^N-1 in order. It emits the index, the
// variable vector and the function value for each minterm, and accumulates the
// true-minterm count and the minterm mask (the canonical sum-of-products).
// The optional consumer backpressure port 'ready' exists only when the
// TT_SWEEP_STALL_EN macro is defined.
module truth_table_sweeper #(
    parameter int                N       = 3,
    parameter logic [(1<<N)-1:0] TT_INIT = 8'hF4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tt_load,
    input  logic [(1<<N)-1:0]   tt_in,
    input  logic                start,
`ifdef TT_SWEEP_STALL_EN
    input  logic                ready,
`endif
    output logic                valid,
    output logic [N-1:0]        minterm,
    output logic [N-1:0]        vars,
    output logic                f_out,
    output logic                busy,
    output logic                done,
    output logic [N:0]          ones_count,
    output logic [(1<<N)-1:0]   sop_mask
);

    localparam int            W    = 1 << N;
    localparam logic [N-1:0]  LAST = N'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   tt_q, tt_d;
    logic [N-1:0]   minterm_q, minterm_d;
    logic           valid_q, valid_d;
    logic           f_out_q, f_out_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N:0]     ones_count_q, ones_count_d;
    logic [W-1:0]   sop_mask_q, sop_mask_d;

    logic [W-1:0]   tt_next;
    logic [N-1:0]   minterm_inc;
    logic           accept;

    // A load in the same cycle as start must be visible to the first step,
    // so the sweep reads the table the register is about to hold.
    assign tt_next     = tt_load ? tt_in : tt_q;
    assign minterm_inc = minterm_q + N'(1);

`ifdef TT_SWEEP_STALL_EN
    assign accept = valid_q & ready;
`else
    assign accept = valid_q;
`endif

    // Next-state and next-output logic; every output is precomputed here so the
    // registered values line up with the minterm they describe.
    always_comb begin
        state_d      = state_q;
        tt_d         = tt_q;
        minterm_d    = minterm_q;
        valid_d      = valid_q;
        f_out_d      = f_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ones_count_d = ones_count_q;
        sop_mask_d   = sop_mask_q;

        case (state_q)
            IDLE, DONE: begin
                tt_d    = tt_next;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d      = SWEEP;
                    minterm_d    = '0;
                    ones_count_d = '0;
                    sop_mask_d   = '0;
                    valid_d      = 1'b1;
                    busy_d       = 1'b1;
                    f_out_d      = tt_next[0];
                end
            end
            SWEEP: begin
                if (accept) begin
                    ones_count_d            = ones_count_q + (N+1)'(f_out_q);
                    sop_mask_d[minterm_q]   = sop_mask_q[minterm_q] | f_out_q;
                    if (minterm_q == LAST) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        minterm_d = minterm_inc;
                        f_out_d   = tt_q[minterm_inc];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tt_q         <= TT_INIT;
            minterm_q    <= '0;
            valid_q      <= 1'b0;
            f_out_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ones_count_q <= '0;
            sop_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            tt_q         <= tt_d;
            minterm_q    <= minterm_d;
            valid_q      <= valid_d;
            f_out_q      <= f_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ones_count_q <= ones_count_d;
            sop_mask_q   <= sop_mask_d;
        end
    end

    assign valid      = valid_q;
    assign minterm    = minterm_q;
    assign vars       = minterm_q;
    assign f_out      = f_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_count_q;
    assign sop_mask   = sop_mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: drives directed and randomly generated truth tables
// through an N=3 sweeper (default table) and checks each emitted step against a
// reference built from the table value itself; a second N=4 instance covers a
// non-default width and reset table.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        tt_load;
    logic [7:0]  tt_in;
    logic        start;
`ifdef TT_SWEEP_STALL_EN
    logic        ready;
`endif
    logic        valid, f_out, busy, done;
    logic [2:0]  minterm, vars;
    logic [3:0]  ones_count;
    logic [7:0]  sop_mask;

    logic        start4;
    logic        valid4, f_out4, busy4, done4;
    logic [3:0]  minterm4, vars4;
    logic [4:0]  ones_count4;
    logic [15:0] sop_mask4;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    truth_table_sweeper #(.N(3), .TT_INIT(8'hF4)) u_dut (
        .clk(clk), .rst(rst), .tt_load(tt_load), .tt_in(tt_in), .start(start),
`ifdef TT_SWEEP_STALL_EN
        .ready(ready),
`endif
        .valid(valid), .minterm(minterm), .vars(vars), .f_out(f_out),
        .busy(busy), .done(done), .ones_count(ones_count), .sop_mask(sop_mask)
    );

    truth_table_sweeper #(.N(4), .TT_INIT(16'h8001)) u_dut4 (
        .clk(clk), .rst(rst), .tt_load(1'b0), .tt_in(16'h0000), .start(start4),
`ifdef TT_SWEEP_STALL_EN
        .ready(1'b1),
`endif
        .valid(valid4), .minterm(minterm4), .vars(vars4), .f_out(f_out4),
        .busy(busy4), .done(done4), .ones_count(ones_count4), .sop_mask(sop_mask4)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] tab, input logic st);
        tt_load = ld;
        tt_in   = tab;
        start   = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one time unit after the edge that sampled start. 'inject' fires a
    // start pulse and an 8'hFF load at minterm 3; 'stall_at' drops ready there
    // for three cycles when backpressure is built in.
    task automatic sweep3(input logic [7:0] tab, input bit inject, input int stall_at);
        int         k      = cyc;
        int         stalls = 0;
        int         ones   = 0;
        logic [7:0] mask   = 8'h00;
        for (int m = 0; m < 8; m++) begin
            checkOutput("valid", valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("done_low", done, 0);
            checkOutput("minterm", minterm, m);
            checkOutput("vars", vars, m);
            checkOutput("f_out", f_out, (tab >> m) & 1);
            checkOutput("ones_running", ones_count, ones);
            checkOutput("mask_running", sop_mask, mask);
`ifdef TT_SWEEP_STALL_EN
            if (m == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    stalls++;
                    checkOutput("stall_minterm", minterm, m);
                    checkOutput("stall_f_out", f_out, (tab >> m) & 1);
                    checkOutput("stall_valid", valid, 1);
                    checkOutput("stall_ones", ones_count, ones);
                end
                ready = 1'b1;
            end
`else
            if (stall_at == m) stalls = 0;
`endif
            if (inject && m == 3) applyStimulus(1'b1, 8'hFF, 1'b1);
            if (tab[m]) begin
                ones++;
                mask[m] = 1'b1;
            end
            step();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("valid_at_done", valid, 0);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("done_latency", cyc - k, 8 + stalls);
        checkOutput("ones_final", ones_count, $countones(tab));
        checkOutput("mask_final", sop_mask, tab);
    endtask

    task automatic idleCheck(input logic [7:0] tab);
        step();
        checkOutput("idle_done", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", valid, 0);
        checkOutput("idle_minterm_hold", minterm, 7);
        checkOutput("idle_ones_hold", ones_count, $countones(tab));
        checkOutput("idle_mask_hold", sop_mask, tab);
    endtask

    initial begin
        logic [7:0] tab;
        int         k4;

        rst    = 1'b1;
        start4 = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
`ifdef TT_SWEEP_STALL_EN
        ready  = 1'b1;
`endif
        #1;
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_minterm", minterm, 0);
        checkOutput("rst_f_out", f_out, 0);
        checkOutput("rst_ones", ones_count, 0);
        checkOutput("rst_mask", sop_mask, 0);
        step();
        step();
        rst = 1'b0;
        step();

        $display("[TB] default table sweep");
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        sweep3(8'hF4, 1'b0, -1);
        idleCheck(8'hF4);

        $display("[TB] load 8'h96, mid-sweep start and load are ignored");
        applyStimulus(1'b1, 8'h96, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        sweep3(8'h96, 1'b1, -1);
        idleCheck(8'h96);

        $display("[TB] stalled sweep of the 8'h96 table");
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        sweep3(8'h96, 1'b0, 2);
        idleCheck(8'h96);

        $display("[TB] random tables, load with start, some back-to-back from DONE");
        for (int i = 0; i < 8; i++) begin
            tab = 8'($urandom_range(0, 255));
            applyStimulus(1'b1, tab, 1'b1);
            step();
            applyStimulus(1'b0, 8'h00, 1'b0);
            sweep3(tab, 1'b0, -1);
            if ($urandom_range(0, 1) == 1) idleCheck(tab);
        end
        step();

        $display("[TB] reset in the middle of a sweep");
        applyStimulus(1'b1, 8'h33, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int s = 0; s < 4; s++) step();
        checkOutput("pre_rst_minterm", minterm, 4);
        checkOutput("pre_rst_ones", ones_count, 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_minterm", minterm, 0);
        checkOutput("mid_rst_ones", ones_count, 0);
        checkOutput("mid_rst_mask", sop_mask, 0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(1'b0, 8'h00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0);
        sweep3(8'hF4, 1'b0, -1);
        idleCheck(8'hF4);

        $display("[TB] N=4 instance with 16'h8001 reset table");
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        k4 = cyc;
        for (int m = 0; m < 16; m++) begin
            checkOutput("n4_valid", valid4, 1);
            checkOutput("n4_minterm", minterm4, m);
            checkOutput("n4_f_out", f_out4, (32'h8001 >> m) & 1);
            step();
        end
        checkOutput("n4_done", done4, 1);
        checkOutput("n4_busy", busy4, 0);
        checkOutput("n4_latency", cyc - k4, 16);
        checkOutput("n4_ones", ones_count4, 2);
        checkOutput("n4_mask", sop_mask4, 16'h8001);
        step();
        checkOutput("n4_done_low", done4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
